// File: rtl/display_sequencer_if.sv
// Signal bundle between the display sequencer and its neighbours: control
// pulses and the countdown strobe in, countdown enable and LED/stage readout out.
interface display_sequencer_if #(
  parameter int NUM_STAGES = 8,
  parameter int STAGE_W    = $clog2(NUM_STAGES)
);
  logic                  start;
  logic                  pause;
  logic                  display_next;
  logic                  enable;
  logic [STAGE_W-1:0]    stage;
  logic [NUM_STAGES-1:0] leds;
  logic                  busy;
  logic                  done;

  modport master (
    output start, pause, display_next,
    input  enable, stage, leds, busy, done
  );

  modport slave (
    input  start, pause, display_next,
    output enable, stage, leds, busy, done
  );
endinterface

// File: rtl/display_sequencer.sv
// Steps a stage counter and one-hot LED pattern on each rising edge of the
// countdown strobe, and gates the countdown while idle, paused or finished.
module display_sequencer #(
  parameter int NUM_STAGES = 8,
  parameter int LOOP       = 0,
  parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
  input  logic          clk,
  input  logic          rst_n,
  display_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] LED_FIRST  = NUM_STAGES'(1);

  state_t                state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [NUM_STAGES-1:0] leds_q, leds_d;
  logic                  enable_q, enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  prev_next_q;

  logic                  adv;
  logic [STAGE_W-1:0]    stage_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      leds_q      <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prev_next_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      leds_q      <= leds_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      prev_next_q <= bus.display_next;
    end
  end

  // start beats adv beats pause; a coincident pause still lands in PAUSE
  // after an advance unless that advance finished the sequence.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    leds_d    = leds_q;
    enable_d  = enable_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    adv       = bus.display_next & ~prev_next_q;
    stage_inc = stage_q + STAGE_W'(1);

    if (bus.start) begin
      state_d  = RUN;
      stage_d  = '0;
      leds_d   = LED_FIRST;
      enable_d = 1'b1;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (adv) begin
            if (stage_q == LAST_STAGE) begin
              if (LOOP != 0) begin
                stage_d = '0;
                leds_d  = LED_FIRST;
              end else begin
                state_d  = DONE;
                enable_d = 1'b0;
                leds_d   = '1;
                done_d   = 1'b1;
                busy_d   = 1'b0;
              end
            end else begin
              stage_d = stage_inc;
              leds_d  = LED_FIRST << stage_inc;
            end
          end
          if (bus.pause && (state_d != DONE)) begin
            state_d  = PAUSE;
            enable_d = 1'b0;
          end
        end
        PAUSE: begin
          if (bus.pause) begin
            state_d  = RUN;
            enable_d = 1'b1;
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.enable = enable_q;
  assign bus.stage  = stage_q;
  assign bus.leds   = leds_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Checks a non-looping and a looping sequencer side by side against a
// stage/phase reference model, a vector table and hand-written corner cases.
module tb_display_sequencer;

  localparam int N = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_PAUSE = 2;
  localparam int PH_DONE  = 3;

  logic clk;
  logic rst_n;

  int nChecks = 0;
  int nFails  = 0;

  int mPhase[2];
  int mStage[2];
  bit mPrev[2];
  bit mDone[2];
  bit sawDoneLoop;

  display_sequencer_if #(.NUM_STAGES(N)) bus0 ();
  display_sequencer_if #(.NUM_STAGES(N)) bus1 ();

  display_sequencer #(.NUM_STAGES(N), .LOOP(0)) dutStop (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  display_sequencer #(.NUM_STAGES(N), .LOOP(1)) dutLoop (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         s;
    bit         p;
    bit         n;
    int         expStage;
    logic [7:0] expLeds;
    bit         expEn;
    bit         expBusy;
    bit         expDone;
  } vec_t;

  vec_t vecs[10];

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mPhase[i] = PH_IDLE;
      mStage[i] = 0;
      mPrev[i]  = 1'b0;
      mDone[i]  = 1'b0;
    end
  endtask

  // One clock of the behavioural rules for both variants (index = LOOP).
  task automatic stepModel(input bit s, input bit p, input bit n);
    bit edgeSeen;
    for (int i = 0; i < 2; i++) begin
      edgeSeen = n && !mPrev[i];
      mPrev[i] = n;
      mDone[i] = 1'b0;
      if (s) begin
        mPhase[i] = PH_RUN;
        mStage[i] = 0;
      end else if (mPhase[i] == PH_RUN) begin
        if (edgeSeen) begin
          if (mStage[i] < N - 1) begin
            mStage[i] = mStage[i] + 1;
          end else if (i == 1) begin
            mStage[i] = 0;
          end else begin
            mPhase[i] = PH_DONE;
            mDone[i]  = 1'b1;
          end
        end
        if (p && mPhase[i] != PH_DONE) mPhase[i] = PH_PAUSE;
      end else if (mPhase[i] == PH_PAUSE && p) begin
        mPhase[i] = PH_RUN;
      end
    end
  endtask

  task automatic compareOne(input int i, input logic en, input logic [2:0] st,
                            input logic [7:0] ld, input logic bz, input logic dn);
    logic [7:0] one;
    logic [7:0] expLeds;
    one = 8'h01;
    if (mPhase[i] == PH_DONE)      expLeds = 8'hFF;
    else if (mPhase[i] == PH_IDLE) expLeds = 8'h00;
    else                           expLeds = one << mStage[i];
    checkField($sformatf("model_dut%0d_enable", i), 32'(en), 32'(mPhase[i] == PH_RUN));
    checkField($sformatf("model_dut%0d_stage", i), 32'(st), 32'(mStage[i]));
    checkField($sformatf("model_dut%0d_leds", i), 32'(ld), 32'(expLeds));
    checkField($sformatf("model_dut%0d_busy", i), 32'(bz),
               32'(mPhase[i] == PH_RUN || mPhase[i] == PH_PAUSE));
    checkField($sformatf("model_dut%0d_done", i), 32'(dn), 32'(mDone[i]));
  endtask

  task automatic checkOutput();
    compareOne(0, bus0.enable, bus0.stage, bus0.leds, bus0.busy, bus0.done);
    compareOne(1, bus1.enable, bus1.stage, bus1.leds, bus1.busy, bus1.done);
    if (bus1.done === 1'b1) sawDoneLoop = 1'b1;
  endtask

  task automatic expectOut(input string tag, input int i, input logic en, input logic [2:0] st,
                           input logic [7:0] ld, input logic bz, input logic dn);
    if (i == 0) begin
      checkField({tag, "_dut0_enable"}, 32'(bus0.enable), 32'(en));
      checkField({tag, "_dut0_stage"}, 32'(bus0.stage), 32'(st));
      checkField({tag, "_dut0_leds"}, 32'(bus0.leds), 32'(ld));
      checkField({tag, "_dut0_busy"}, 32'(bus0.busy), 32'(bz));
      checkField({tag, "_dut0_done"}, 32'(bus0.done), 32'(dn));
    end else begin
      checkField({tag, "_dut1_enable"}, 32'(bus1.enable), 32'(en));
      checkField({tag, "_dut1_stage"}, 32'(bus1.stage), 32'(st));
      checkField({tag, "_dut1_leds"}, 32'(bus1.leds), 32'(ld));
      checkField({tag, "_dut1_busy"}, 32'(bus1.busy), 32'(bz));
      checkField({tag, "_dut1_done"}, 32'(bus1.done), 32'(dn));
    end
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit n);
    @(negedge clk);
    bus0.start = s; bus0.pause = p; bus0.display_next = n;
    bus1.start = s; bus1.pause = p; bus1.display_next = n;
    @(posedge clk);
    #1;
    stepModel(s, p, n);
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    bus0.start = 1'b0; bus0.pause = 1'b0; bus0.display_next = 1'b0;
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.display_next = 1'b0;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] one;
    one = 8'h01;
    sawDoneLoop = 1'b0;
    rst_n = 1'b1;
    bus0.start = 1'b0; bus0.pause = 1'b0; bus0.display_next = 1'b0;
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.display_next = 1'b0;

    vecs[0] = '{1, 0, 0, 0, 8'h01, 1, 1, 0};
    vecs[1] = '{0, 0, 1, 1, 8'h02, 1, 1, 0};
    vecs[2] = '{0, 0, 1, 1, 8'h02, 1, 1, 0};
    vecs[3] = '{0, 1, 0, 1, 8'h02, 0, 1, 0};
    vecs[4] = '{0, 0, 1, 1, 8'h02, 0, 1, 0};
    vecs[5] = '{0, 0, 0, 1, 8'h02, 0, 1, 0};
    vecs[6] = '{0, 1, 0, 1, 8'h02, 1, 1, 0};
    vecs[7] = '{0, 1, 1, 2, 8'h04, 0, 1, 0};
    vecs[8] = '{1, 0, 0, 0, 8'h01, 1, 1, 0};
    vecs[9] = '{0, 0, 1, 1, 8'h02, 1, 1, 0};

    $display("[TB] reset and idle");
    #2;
    doReset();
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0, 1'b0);
    expectOut("idle", 0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    $display("[TB] vector table");
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].s, vecs[v].p, vecs[v].n);
      for (int i = 0; i < 2; i++)
        expectOut($sformatf("vec%0d", v), i, vecs[v].expEn, 3'(vecs[v].expStage),
                  vecs[v].expLeds, vecs[v].expBusy, vecs[v].expDone);
    end

    $display("[TB] full run and wrap");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      for (int g = 0; g < 999; g++) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k < 8)
        expectOut($sformatf("run%0d", k), 0, 1'b1, 3'(k), one << k, 1'b1, 1'b0);
      else if (k == 8)
        expectOut("run8", 0, 1'b0, 3'd7, 8'hFF, 1'b0, 1'b1);
      else
        expectOut("run9", 0, 1'b0, 3'd7, 8'hFF, 1'b0, 1'b0);
      expectOut($sformatf("wrap%0d", k), 1, 1'b1, 3'(k % 8), one << (k % 8), 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (k == 8) expectOut("done_drop", 0, 1'b0, 3'd7, 8'hFF, 1'b0, 1'b0);
    end
    checkField("loop_never_done", 32'(sawDoneLoop), 32'd0);

    $display("[TB] level input");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) applyStimulus(1'b0, 1'b0, 1'b1);
    expectOut("level", 0, 1'b1, 3'd1, 8'h02, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] pause");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pulse();
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectOut("paused", 0, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) pulse();
    expectOut("paused_held", 0, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectOut("resumed", 0, 1'b1, 3'd3, 8'h08, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectOut("after_resume", 0, 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] mid-run reset");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) pulse();
    expectOut("stage5", 0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expectOut("async_rst", 0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    expectOut("async_rst", 1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectOut("start_with_pulse", 0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectOut("no_extra_adv", 0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);

    $display("[TB] random");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
